div_bcd_formatter: RTL and testbench

Sequential binary-to-BCD formatter that sits directly downstream of the calculator's divider core. It captures quotient and remainder when the divider signals done, and converts each to packed BCD with a shared shift-add-3 (double-dabble) datapath. It presents both BCD results plus an error flag to the display/readback logic. Divide-by-zero bypasses conversion and reports an error.

---
 rtl/div_bcd_formatter.sv | 128 ++++++++++++
 tb/tb_div_bcd_formatter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/div_bcd_formatter.sv
// Binary-to-BCD formatter for divider results: captures quotient/remainder and
// converts each in turn through one shared shift-add-3 datapath.
module div_bcd_formatter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_q,
  input  logic [WIDTH-1:0]      in_r,
  input  logic                  in_div_zero,
  input  logic                  clr_ovr,
  output logic                  busy,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic                  err,
  output logic                  overrun
);

  localparam int BW   = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(1);

  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] bin;
  logic [BW-1:0]    bcd;
  logic [CNTW-1:0]  cnt;
  logic [WIDTH-1:0] r_hold;
  logic [BW-1:0]    q_tmp;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_next;
  logic [WIDTH-1:0] bin_next;
  logic             converting;

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_next = BW'({adj, bin} >> (WIDTH - 1));
    bin_next = {bin[WIDTH-2:0], 1'b0};
  end

  assign converting = (state == CONV_Q) || (state == CONV_R);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      r_hold    <= '0;
      q_tmp     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      q_bcd     <= '0;
      r_bcd     <= '0;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      // A drop in the same cycle as a clear keeps overrun set.
      if (in_valid && converting)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (in_valid) begin
            if (in_div_zero) begin
              q_bcd     <= '0;
              r_bcd     <= '0;
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              r_hold <= in_r;
              bin    <= in_q;
              bcd    <= '0;
              cnt    <= CNT_LOAD;
              busy   <= 1'b1;
              state  <= CONV_Q;
            end
          end else begin
            state <= IDLE;
          end
        end
        CONV_Q: begin
          bcd <= bcd_next;
          bin <= bin_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            q_tmp <= bcd_next;
            bin   <= r_hold;
            bcd   <= '0;
            cnt   <= CNT_LOAD;
            state <= CONV_R;
          end
        end
        CONV_R: begin
          bcd <= bcd_next;
          bin <= bin_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            q_bcd     <= q_tmp;
            r_bcd     <= bcd_next;
            err       <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Directed self-checking bench for div_bcd_formatter; inputs change and outputs
// are sampled on the falling clock edge.
module tb_div_bcd_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_q = '0;
  logic [7:0]  in_r = '0;
  logic        in_div_zero = 1'b0;
  logic        clr_ovr = 1'b0;
  logic        busy;
  logic        out_valid;
  logic [11:0] q_bcd;
  logic [11:0] r_bcd;
  logic        err;
  logic        overrun;

  int checks = 0;
  int failures = 0;

  div_bcd_formatter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_q(in_q), .in_r(in_r),
    .in_div_zero(in_div_zero), .clr_ovr(clr_ovr), .busy(busy),
    .out_valid(out_valid), .q_bcd(q_bcd), .r_bcd(r_bcd), .err(err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pulse in_valid for one edge, then wait (bounded) for out_valid.
  // lat = rising edges after the sampling edge; bsy = busy-high samples seen.
  task automatic run_op(input logic [7:0] q, input logic [7:0] r, input logic dz,
                        output int lat, output int bsy);
    in_q = q; in_r = r; in_div_zero = dz; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_div_zero = 1'b0;
    lat = 0; bsy = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    checks++; if ({busy, out_valid, err, overrun} !== 4'b0000) begin failures++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, out_valid, err, overrun}); end
    checks++; if ({q_bcd, r_bcd} !== 24'h0) begin failures++;
      $display("FAIL reset_data got=%h exp=000000", {q_bcd, r_bcd}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_max;
    int lat, bsy;
    run_op(8'd255, 8'd0, 1'b0, lat, bsy);
    checks++; if (bsy !== 16) begin failures++;
      $display("FAIL max_busy_cycles got=%0d exp=16", bsy); end
    checks++; if ({out_valid, err, q_bcd, r_bcd} !== {2'b10, 24'h255000}) begin failures++;
      $display("FAIL max_result got=%b%b %h/%h exp=10 255/000", out_valid, err, q_bcd, r_bcd); end
    @(negedge clk);
  endtask

  task automatic test_latency;
    int lat, bsy;
    run_op(8'd28, 8'd4, 1'b0, lat, bsy);
    checks++; if (lat !== 16) begin failures++;
      $display("FAIL latency got=%0d exp=16", lat); end
    checks++; if ({q_bcd, r_bcd, err} !== {24'h028004, 1'b0}) begin failures++;
      $display("FAIL div200_7 got=%h/%h err=%b exp=028/004 err=0", q_bcd, r_bcd, err); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL out_valid_width got=%b exp=0", out_valid); end
    checks++; if ({q_bcd, r_bcd} !== 24'h028004) begin failures++;
      $display("FAIL hold_after_done got=%h exp=028004", {q_bcd, r_bcd}); end
  endtask

  task automatic test_div_zero;
    int lat, bsy;
    run_op(8'hFF, 8'h12, 1'b1, lat, bsy);
    checks++; if ({lat, bsy} !== {32'd0, 32'd0}) begin failures++;
      $display("FAIL dz_latency got=lat%0d busy%0d exp=lat0 busy0", lat, bsy); end
    checks++; if ({out_valid, err, busy, q_bcd, r_bcd} !== {3'b110, 24'h0}) begin failures++;
      $display("FAIL dz_result got=%b%b%b %h/%h exp=110 000/000", out_valid, err, busy, q_bcd, r_bcd); end
    @(negedge clk);
    run_op(8'd99, 8'd0, 1'b0, lat, bsy);
    checks++; if ({q_bcd, r_bcd, err, lat} !== {24'h099000, 1'b0, 32'd16}) begin failures++;
      $display("FAIL after_dz got=%h/%h err=%b lat=%0d exp=099/000 err=0 lat=16", q_bcd, r_bcd, err, lat); end
    @(negedge clk);
  endtask

  task automatic test_overrun;
    int lat;
    in_q = 8'd123; in_r = 8'd45; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; lat = 0;
    repeat (4) begin @(negedge clk); lat++; end
    in_q = 8'd7; in_r = 8'd0; in_valid = 1'b1;
    @(negedge clk); lat++;
    in_valid = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++;
      $display("FAIL overrun_set got=%b exp=1", overrun); end
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    checks++; if ({q_bcd, r_bcd, lat} !== {24'h123045, 32'd16}) begin failures++;
      $display("FAIL overrun_result got=%h/%h lat=%0d exp=123/045 lat=16", q_bcd, r_bcd, lat); end
    @(negedge clk);
    checks++; if (overrun !== 1'b1) begin failures++;
      $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++;
      $display("FAIL overrun_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_mid;
    int lat, bsy, seen;
    in_q = 8'd200; in_r = 8'd13; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({busy, out_valid, err, overrun, q_bcd, r_bcd} !== 28'h0) begin failures++;
      $display("FAIL async_reset got=%b%b%b%b %h/%h exp=0000 000/000", busy, out_valid, err, overrun, q_bcd, r_bcd); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (25) begin @(negedge clk); if (out_valid || busy) seen++; end
    checks++; if (seen !== 0) begin failures++;
      $display("FAIL discarded_op got=%0d exp=0", seen); end
    run_op(8'd64, 8'd1, 1'b0, lat, bsy);
    checks++; if ({q_bcd, r_bcd, lat} !== {24'h064001, 32'd16}) begin failures++;
      $display("FAIL post_reset_op got=%h/%h lat=%0d exp=064/001 lat=16", q_bcd, r_bcd, lat); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat;
    in_q = 8'd150; in_r = 8'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    checks++; if ({out_valid, q_bcd, r_bcd} !== {1'b1, 24'h150009}) begin failures++;
      $display("FAIL b2b_first got=%b %h/%h exp=1 150/009", out_valid, q_bcd, r_bcd); end
    in_q = 8'd1; in_r = 8'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({busy, out_valid} !== 2'b10) begin failures++;
      $display("FAIL b2b_accept got=busy%b ov%b exp=busy1 ov0", busy, out_valid); end
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    checks++; if ({q_bcd, r_bcd, lat, overrun} !== {24'h001002, 32'd16, 1'b0}) begin failures++;
      $display("FAIL b2b_second got=%h/%h lat=%0d ovr=%b exp=001/002 lat=16 ovr=0", q_bcd, r_bcd, lat, overrun); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_max;
    test_latency;
    test_div_zero;
    test_overrun;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
